seq_signed_mult: RTL and testbench

//  Parametrised sequential shift-add multiplier with its own control FSM.
//  - Multiplies two WIDTH-bit operands into a full 2*WIDTH-bit product, one multiplier bit per clock.
//  - Supports signed (two's complement) and unsigned modes, selected per operation.
//  - start/busy/done handshake, so no external sequencer is needed.
//  - Sits between the operand registers and the result bus of the datapath.

---
 rtl/seq_mult_pkg.sv | 25 ++
 rtl/mag_conv.sv | 23 ++
 rtl/seq_signed_mult.sv | 142 ++++++++++++++
 tb/tb_seq_signed_mult.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/seq_mult_pkg.sv
// rtl/seq_mult_pkg.sv - shared state encoding and negate helper for seq_signed_mult
//
// Contents:
//   state_t    FSM encoding S_IDLE=0, S_CALC=1, S_DONE=2 (3 is unused and behaves as IDLE)
//   NEG_MAX_W  widest value twos_neg can handle
//   twos_neg   two's complement negate; callers zero-extend in and size-cast out

package seq_mult_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Product width 2*WIDTH must fit here, so WIDTH is limited to 32.
  localparam int NEG_MAX_W = 64;

  // Negation mod 2^64. The low N bits of the result are the N-bit negation
  // of the low N bits of v, so a truncating size cast gives any narrower width.
  function automatic logic [NEG_MAX_W-1:0] twos_neg(input logic [NEG_MAX_W-1:0] v);
    return ~v + 64'd1;
  endfunction

endpackage

// File: rtl/mag_conv.sv
// rtl/mag_conv.sv - operand to (unsigned magnitude, sign) converter
//
// Ports:
//   in_val     in   WIDTH  raw operand
//   is_signed  in   1      1 = in_val is two's complement
//   magnitude  out  WIDTH  |in_val| as unsigned; the most negative value maps to 2^(WIDTH-1)
//   sign_bit   out  1      1 when in_val is negative in signed mode

module mag_conv
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] in_val,
  input  logic             is_signed,
  output logic [WIDTH-1:0] magnitude,
  output logic             sign_bit
);

  assign sign_bit  = is_signed & in_val[WIDTH-1];
  assign magnitude = sign_bit ? WIDTH'(twos_neg(64'(in_val))) : in_val;

endmodule

// File: rtl/seq_signed_mult.sv
// rtl/seq_signed_mult.sv - sequential shift-add multiplier, signed/unsigned, start/busy/done
//
// Ports:
//   clk           in   1        clock, all logic on posedge
//   rst           in   1        synchronous active-high reset; aborts any operation
//   start         in   1        request; accepted only in IDLE or DONE
//   is_signed     in   1        1 = two's complement operands; sampled with start
//   multiplier    in   WIDTH    operand A; sampled with start
//   multiplicand  in   WIDTH    operand B; sampled with start
//   busy          out  1        high while in CALC
//   done          out  1        one-cycle pulse, product valid
//   product       out  2*WIDTH  result, held until the next result write
//   zflag         out  1        product == 0
//
// One multiplier bit per clock: WIDTH CALC edges, then one DONE cycle.
// Operands are multiplied as magnitudes and the sign is applied on the
// final edge, so the accumulator never needs sign handling.

module seq_signed_mult
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 is_signed,
  input  logic [WIDTH-1:0]     multiplier,
  input  logic [WIDTH-1:0]     multiplicand,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product,
  output logic                 zflag
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int PW    = 2 * WIDTH;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           state;
  state_t           state_n;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] mag_a;    // shifts right one bit per step
  logic [WIDTH-1:0] mag_b;
  logic [PW-1:0]    acc;
  logic             neg;

  logic [WIDTH-1:0] mag_a_in;
  logic [WIDTH-1:0] mag_b_in;
  logic             sign_a;
  logic             sign_b;

  logic             load;
  logic             step;
  logic             last_step;
  logic [PW-1:0]    addend;
  logic [PW-1:0]    acc_sum;
  logic [PW-1:0]    result;

  mag_conv #(.WIDTH(WIDTH)) u_conv_a (
    .in_val    (multiplier),
    .is_signed (is_signed),
    .magnitude (mag_a_in),
    .sign_bit  (sign_a)
  );

  mag_conv #(.WIDTH(WIDTH)) u_conv_b (
    .in_val    (multiplicand),
    .is_signed (is_signed),
    .magnitude (mag_b_in),
    .sign_bit  (sign_b)
  );

  // Step arithmetic. The largest partial sum is (2^W-1)^2 < 2^(2W), so the
  // 2*WIDTH-bit accumulator cannot overflow.
  always_comb begin
    addend  = PW'(mag_b) << count;
    acc_sum = acc + (mag_a[0] ? addend : '0);
    result  = neg ? PW'(twos_neg(64'(acc_sum))) : acc_sum;
  end

  // Next state and control decode. The unused encoding falls into the
  // default branch and therefore behaves exactly like IDLE.
  always_comb begin
    state_n   = state;
    load      = 1'b0;
    step      = 1'b0;
    last_step = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_CALC: begin
        busy      = 1'b1;
        step      = 1'b1;
        last_step = (count == LAST_CNT);
        if (last_step) begin
          state_n = S_DONE;
        end
      end
      S_DONE: begin
        done = 1'b1;
        load = start;
        state_n = start ? S_CALC : S_IDLE;
      end
      default: begin
        load = start;
        state_n = start ? S_CALC : S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      count   <= '0;
      mag_a   <= '0;
      mag_b   <= '0;
      acc     <= '0;
      neg     <= 1'b0;
      product <= '0;
      zflag   <= 1'b1;
    end else begin
      state <= state_n;
      if (load) begin
        mag_a <= mag_a_in;
        mag_b <= mag_b_in;
        neg   <= sign_a ^ sign_b;
        acc   <= '0;
        count <= '0;
      end else if (step) begin
        acc   <= acc_sum;
        mag_a <= mag_a >> 1;
        count <= count + 1'b1;
        if (last_step) begin
          product <= result;
          zflag   <= (acc_sum == '0);
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_signed_mult.sv
// tb/tb_seq_signed_mult.sv - directed and random checks of seq_signed_mult

module tb_seq_signed_mult;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        start8 = 1'b0;
  logic        sg8 = 1'b0;
  logic [7:0]  a8 = '0;
  logic [7:0]  b8 = '0;
  logic        busy8;
  logic        done8;
  logic [15:0] p8;
  logic        z8;

  logic        start16 = 1'b0;
  logic        sg16 = 1'b0;
  logic [15:0] a16 = '0;
  logic [15:0] b16 = '0;
  logic        busy16;
  logic        done16;
  logic [31:0] p16;
  logic        z16;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        sg;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] p;
    logic        z;
  } vec_t;

  vec_t vecs[12];

  always #5 clk = ~clk;

  seq_signed_mult #(.WIDTH(8)) dut8 (
    .clk          (clk),
    .rst          (rst),
    .start        (start8),
    .is_signed    (sg8),
    .multiplier   (a8),
    .multiplicand (b8),
    .busy         (busy8),
    .done         (done8),
    .product      (p8),
    .zflag        (z8)
  );

  seq_signed_mult #(.WIDTH(16)) dut16 (
    .clk          (clk),
    .rst          (rst),
    .start        (start16),
    .is_signed    (sg16),
    .multiplier   (a16),
    .multiplicand (b16),
    .busy         (busy16),
    .done         (done16),
    .product      (p16),
    .zflag        (z16)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Waits for done after an accepting edge; lat = edges counted, 0 on timeout.
  task automatic wait_done8(output int lat, output logic proto_ok);
    lat = 0;
    proto_ok = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (busy8 && done8) proto_ok = 1'b0;
      if (done8) begin
        lat = i;
        break;
      end
      if (!busy8) proto_ok = 1'b0;
    end
  endtask

  task automatic op8(input logic sg, input logic [7:0] a, input logic [7:0] b,
                     output int lat, output logic proto_ok);
    @(negedge clk);
    start8 = 1'b1; sg8 = sg; a8 = a; b8 = b;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0; sg8 = ~sg; a8 = 8'($urandom); b8 = 8'($urandom);
    wait_done8(lat, proto_ok);
  endtask

  task automatic op16(input logic sg, input logic [15:0] a, input logic [15:0] b, output int lat);
    @(negedge clk);
    start16 = 1'b1; sg16 = sg; a16 = a; b16 = b;
    @(posedge clk);
    @(negedge clk);
    start16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom);
    lat = 0;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk); #1;
      if (done16) begin
        lat = i;
        break;
      end
    end
  endtask

  initial begin
    int          lat;
    logic        pok;
    logic        seen;
    logic        rs;
    logic [15:0] ra;
    logic [15:0] rb;
    logic signed [31:0] sa32;
    logic signed [31:0] sb32;
    logic [31:0] exp32;

    vecs[0]  = '{1'b1, 8'hFD, 8'h07, 16'hFFEB, 1'b0};
    vecs[1]  = '{1'b1, 8'h80, 8'h80, 16'h4000, 1'b0};
    vecs[2]  = '{1'b0, 8'hFF, 8'hFF, 16'hFE01, 1'b0};
    vecs[3]  = '{1'b1, 8'h00, 8'hFB, 16'h0000, 1'b1};
    vecs[4]  = '{1'b1, 8'h05, 8'h00, 16'h0000, 1'b1};
    vecs[5]  = '{1'b0, 8'h80, 8'h80, 16'h4000, 1'b0};
    vecs[6]  = '{1'b1, 8'h7F, 8'h80, 16'hC080, 1'b0};
    vecs[7]  = '{1'b0, 8'h7F, 8'h80, 16'h3F80, 1'b0};
    vecs[8]  = '{1'b1, 8'hFF, 8'hFF, 16'h0001, 1'b0};
    vecs[9]  = '{1'b1, 8'h80, 8'h01, 16'hFF80, 1'b0};
    vecs[10] = '{1'b0, 8'hFF, 8'h01, 16'h00FF, 1'b0};
    vecs[11] = '{1'b1, 8'hF6, 8'h0C, 16'hFF88, 1'b0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", 32'(busy8), 32'd0);
    chk("reset_done", 32'(done8), 32'd0);
    chk("reset_product", 32'(p8), 32'd0);
    chk("reset_zflag", 32'(z8), 32'd1);
    @(negedge clk);
    rst = 1'b0;

    // Table-driven single operations
    foreach (vecs[i]) begin
      op8(vecs[i].sg, vecs[i].a, vecs[i].b, lat, pok);
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd8);
      chk($sformatf("vec%0d_product", i), 32'(p8), 32'(vecs[i].p));
      chk($sformatf("vec%0d_zflag", i), 32'(z8), 32'(vecs[i].z));
      chk($sformatf("vec%0d_busy_done_protocol", i), 32'(pok), 32'd1);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_done_pulse", i), 32'(done8), 32'd0);
      chk($sformatf("vec%0d_product_hold", i), 32'(p8), 32'(vecs[i].p));
    end

    // Start held high: 2*3, then -4*4 accepted from DONE
    @(negedge clk);
    start8 = 1'b1; sg8 = 1'b1; a8 = 8'd2; b8 = 8'd3;
    @(posedge clk);
    @(negedge clk);
    a8 = 8'hFC; b8 = 8'd4;
    wait_done8(lat, pok);
    chk("b2b_first_latency", 32'(lat), 32'd8);
    chk("b2b_first_product", 32'(p8), 32'h0006);
    chk("b2b_first_protocol", 32'(pok), 32'd1);
    @(posedge clk); #1;
    chk("b2b_reaccept_busy", 32'(busy8), 32'd1);
    chk("b2b_product_held_in_calc", 32'(p8), 32'h0006);
    @(negedge clk);
    start8 = 1'b0; a8 = 8'h11; b8 = 8'h22;
    wait_done8(lat, pok);
    chk("b2b_done_spacing", 32'(lat + 1), 32'd9);
    chk("b2b_second_product", 32'(p8), 32'hFFF0);
    chk("b2b_second_zflag", 32'(z8), 32'd0);

    // Reset in the middle of CALC (count=4)
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b1; sg8 = 1'b0; a8 = 8'd5; b8 = 8'd3;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_busy", 32'(busy8), 32'd0);
    chk("abort_done", 32'(done8), 32'd0);
    chk("abort_product", 32'(p8), 32'd0);
    chk("abort_zflag", 32'(z8), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done8 || busy8) seen = 1'b1;
    end
    chk("abort_no_done", 32'(seen), 32'd0);
    op8(1'b1, 8'hF9, 8'h06, lat, pok);
    chk("after_abort_latency", 32'(lat), 32'd8);
    chk("after_abort_product", 32'(p8), 32'hFFD6);

    // WIDTH=16 random sweep against a behavioural product
    for (int n = 0; n < 1000; n++) begin
      rs = 1'(($urandom));
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (n == 0) begin rs = 1'b1; ra = 16'h8000; rb = 16'h8000; end
      if (n == 1) begin rs = 1'b0; ra = 16'hFFFF; rb = 16'hFFFF; end
      if (n == 2) begin rs = 1'b1; ra = 16'h0000; rb = 16'h8001; end
      if (rs) begin
        sa32 = {{16{ra[15]}}, ra};
        sb32 = {{16{rb[15]}}, rb};
        exp32 = 32'(sa32 * sb32);
      end else begin
        exp32 = {16'd0, ra} * {16'd0, rb};
      end
      op16(rs, ra, rb, lat);
      chk($sformatf("w16_op%0d_latency", n), 32'(lat), 32'd16);
      chk($sformatf("w16_op%0d_product s=%0d a=%h b=%h", n, rs, ra, rb), p16, exp32);
      chk($sformatf("w16_op%0d_zflag", n), 32'(z16), 32'(exp32 == 32'd0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
